// File: rtl/peripheral_bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
package peripheral_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   // Read data returned for writes and for timed-out transactions.
   localparam logic [31:0] ERR_DATA = ~32'h0;

   localparam int CNT_W = 8;

endpackage

// File: rtl/peripheral_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single peripheral bus.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | sample requests, pick a winner, latch its command onto the bus
// ST_ACTIVE | bus strobes driven, wait for busy low or busy-cycle timeout
// ST_RESP   | one-cycle ack/data/error to the winner, bus strobes low
module peripheral_bus_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [15:0] m0_address,
   input  logic [3:0]  m0_byteSelect,
   input  logic [31:0] m0_dataWrite,
   output logic [31:0] m0_dataRead,
   output logic        m0_ack,
   output logic        m0_error,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [15:0] m1_address,
   input  logic [3:0]  m1_byteSelect,
   input  logic [31:0] m1_dataWrite,
   output logic [31:0] m1_dataRead,
   output logic        m1_ack,
   output logic        m1_error,
   output logic        peripheralEnable,
   output logic        peripheralBus_we,
   output logic        peripheralBus_oe,
   output logic [15:0] peripheralBus_address,
   output logic [3:0]  peripheralBus_byteSelect,
   output logic [31:0] peripheralBus_dataWrite,
   input  logic        peripheralBus_busy,
   input  logic [31:0] peripheralBus_dataRead
);
   import peripheral_bus_arbiter_pkg::*;

   // Terminal count: the busy cycle on which r_cnt holds this value is the last one allowed.
   localparam logic [CNT_W-1:0] LP_TC = CNT_W'(TIMEOUT - 1);

   arb_state_t       r_state;
   arb_state_t       w_next;
   logic             r_ptr;
   logic             r_gnt;
   logic             r_we;
   logic [CNT_W-1:0] r_cnt;
   logic             r_en;
   logic             r_bus_we;
   logic             r_bus_oe;
   logic [15:0]      r_addr;
   logic [3:0]       r_bsel;
   logic [31:0]      r_wdata;
   logic             r_ack0;
   logic             r_ack1;
   logic             r_err0;
   logic             r_err1;
   logic [31:0]      r_rd0;
   logic [31:0]      r_rd1;

   logic             w_win;
   logic             w_pick;
   logic             w_sel_we;
   logic             w_tout;
   logic             w_done;
   logic [31:0]      w_cap;

   // r_ptr names the master that wins a tie; a lone request always wins.
   assign w_win    = m0_req | m1_req;
   assign w_pick   = (m0_req & m1_req) ? r_ptr : m1_req;
   assign w_sel_we = w_pick ? m1_we : m0_we;
   assign w_tout   = peripheralBus_busy && (r_cnt == LP_TC);
   assign w_done   = !peripheralBus_busy || w_tout;
   assign w_cap    = (w_tout || r_we) ? ERR_DATA : peripheralBus_dataRead;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_win)  w_next = ST_ACTIVE;
         ST_ACTIVE: if (w_done) w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Command latch, busy counter, round-robin pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr    <= 1'b0;
         r_gnt    <= 1'b0;
         r_we     <= 1'b0;
         r_cnt    <= '0;
         r_en     <= 1'b0;
         r_bus_we <= 1'b0;
         r_bus_oe <= 1'b0;
         r_addr   <= '0;
         r_bsel   <= '0;
         r_wdata  <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
         r_rd0    <= '0;
         r_rd1    <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
         r_rd0  <= '0;
         r_rd1  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_win) begin
                  r_gnt    <= w_pick;
                  r_we     <= w_sel_we;
                  r_cnt    <= '0;
                  r_en     <= 1'b1;
                  r_bus_we <= w_sel_we;
                  r_bus_oe <= ~w_sel_we;
                  r_addr   <= w_pick ? m1_address    : m0_address;
                  r_bsel   <= w_pick ? m1_byteSelect : m0_byteSelect;
                  r_wdata  <= w_pick ? m1_dataWrite  : m0_dataWrite;
               end
            end
            ST_ACTIVE: begin
               if (w_done) begin
                  r_en     <= 1'b0;
                  r_bus_we <= 1'b0;
                  r_bus_oe <= 1'b0;
                  r_addr   <= '0;
                  r_bsel   <= '0;
                  r_wdata  <= '0;
                  r_ptr    <= ~r_gnt;
                  r_ack0   <= ~r_gnt;
                  r_ack1   <= r_gnt;
                  r_err0   <= ~r_gnt & w_tout;
                  r_err1   <= r_gnt & w_tout;
                  r_rd0    <= r_gnt ? '0 : w_cap;
                  r_rd1    <= r_gnt ? w_cap : '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: r_cnt <= '0;
            default: ;
         endcase
      end
   end

   assign peripheralEnable         = r_en;
   assign peripheralBus_we         = r_bus_we;
   assign peripheralBus_oe         = r_bus_oe;
   assign peripheralBus_address    = r_addr;
   assign peripheralBus_byteSelect = r_bsel;
   assign peripheralBus_dataWrite  = r_wdata;
   assign m0_ack      = r_ack0;
   assign m1_ack      = r_ack1;
   assign m0_error    = r_err0;
   assign m1_error    = r_err1;
   assign m0_dataRead = r_rd0;
   assign m1_dataRead = r_rd1;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Scoreboard bench for peripheral_bus_arbiter with a busy-stretching peripheral model.
module tb_peripheral_bus_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_address, m1_address;
   logic [3:0]  m0_byteSelect, m1_byteSelect;
   logic [31:0] m0_dataWrite, m1_dataWrite;
   logic [31:0] m0_dataRead, m1_dataRead;
   logic        m0_ack, m1_ack, m0_error, m1_error;
   logic        peripheralEnable, peripheralBus_we, peripheralBus_oe;
   logic [15:0] peripheralBus_address;
   logic [3:0]  peripheralBus_byteSelect;
   logic [31:0] peripheralBus_dataWrite;
   logic        peripheralBus_busy;
   logic [31:0] peripheralBus_dataRead;

   peripheral_bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address),
      .m0_byteSelect(m0_byteSelect), .m0_dataWrite(m0_dataWrite),
      .m0_dataRead(m0_dataRead), .m0_ack(m0_ack), .m0_error(m0_error),
      .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address),
      .m1_byteSelect(m1_byteSelect), .m1_dataWrite(m1_dataWrite),
      .m1_dataRead(m1_dataRead), .m1_ack(m1_ack), .m1_error(m1_error),
      .peripheralEnable(peripheralEnable), .peripheralBus_we(peripheralBus_we),
      .peripheralBus_oe(peripheralBus_oe), .peripheralBus_address(peripheralBus_address),
      .peripheralBus_byteSelect(peripheralBus_byteSelect),
      .peripheralBus_dataWrite(peripheralBus_dataWrite),
      .peripheralBus_busy(peripheralBus_busy), .peripheralBus_dataRead(peripheralBus_dataRead)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          master;
      logic [31:0] data;
      logic        err;
      int          ack_cyc;
      logic        we;
      logic [15:0] addr;
      logic [3:0]  bsel;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          busy_len = 0;
   int          bus_cnt = 0;
   logic [31:0] rd_data = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral model: busy for busy_len enabled cycles, then returns rd_data.
   always @(posedge clk) bus_cnt <= peripheralEnable ? bus_cnt + 1 : 0;
   assign peripheralBus_busy     = peripheralEnable && (bus_cnt < busy_len);
   assign peripheralBus_dataRead = peripheralBus_busy ? (32'hDEAD_0000 | 32'(bus_cnt)) : rd_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each ack, checks bus fields against the pending entry.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (m0_ack || m1_ack) begin
            check("dual_ack", m0_ack & m1_ack, 1'b0);
            check("resp_strobes", {peripheralEnable, peripheralBus_we, peripheralBus_oe}, 3'b000);
            if (sb.size() == 0) begin
               check("spurious_ack", {m0_ack, m1_ack}, 2'b00);
            end else begin
               mon_e = sb.pop_front();
               check("ack_master", m1_ack ? 1 : 0, mon_e.master);
               check("ack_cycle", cyc, mon_e.ack_cyc);
               check("ack_data", m1_ack ? m1_dataRead : m0_dataRead, mon_e.data);
               check("ack_error", m1_ack ? m1_error : m0_error, mon_e.err);
               check("loser_zero", m1_ack ? {m0_error, m0_dataRead} : {m1_error, m1_dataRead}, 0);
            end
         end else begin
            check("idle_resp_zero", {m0_error, m1_error, m0_dataRead, m1_dataRead}, 0);
         end
         if (peripheralEnable) begin
            if (sb.size() == 0) begin
               check("spurious_en", peripheralEnable, 1'b0);
            end else begin
               check("bus_fields",
                     {peripheralBus_we, peripheralBus_oe, peripheralBus_address,
                      peripheralBus_byteSelect, peripheralBus_dataWrite},
                     {sb[0].we, ~sb[0].we, sb[0].addr, sb[0].bsel, sb[0].wdata});
            end
         end
      end
   end

   task automatic set_master(input int m, input logic we, input logic [15:0] addr,
                             input logic [3:0] bsel, input logic [31:0] wdata);
      if (m == 0) begin
         m0_we = we; m0_address = addr; m0_byteSelect = bsel; m0_dataWrite = wdata;
      end else begin
         m1_we = we; m1_address = addr; m1_byteSelect = bsel; m1_dataWrite = wdata;
      end
   endtask

   function automatic exp_t mk_exp(input int m, input logic we, input logic [15:0] addr,
                                   input logic [3:0] bsel, input logic [31:0] wdata,
                                   input int blen, input logic [31:0] rdata, input int start);
      exp_t e;
      logic tout;
      int   k;
      tout      = (blen >= TB_TIMEOUT);
      k         = tout ? TB_TIMEOUT : blen + 1;
      e.master  = m;
      e.we      = we;
      e.addr    = addr;
      e.bsel    = bsel;
      e.wdata   = wdata;
      e.err     = tout;
      e.data    = (tout || we) ? 32'hFFFF_FFFF : rdata;
      e.ack_cyc = start + k + 1;
      return e;
   endfunction

   task automatic run_txn(input int m, input logic we, input logic [15:0] addr,
                          input logic [3:0] bsel, input logic [31:0] wdata,
                          input int blen, input logic [31:0] rdata);
      logic got;
      @(negedge clk);
      busy_len = blen;
      rd_data  = rdata;
      set_master(m, we, addr, bsel, wdata);
      sb.push_back(mk_exp(m, we, addr, bsel, wdata, blen, rdata, cyc));
      if (m == 0) m0_req = 1'b1; else m1_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #1;
         got = (m == 0) ? m0_ack : m1_ack;
      end
      check("ack_seen", got, 1'b1);
      @(negedge clk);
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   // Both masters request continuously for four transactions; first is the expected first grant.
   task automatic run_contention(input int first);
      int n;
      int start;
      @(negedge clk);
      busy_len = 0;
      rd_data  = 32'h0BAD_F00D;
      set_master(0, 1'b0, 16'h0200, 4'h3, 32'h1111_2222);
      set_master(1, 1'b1, 16'h0300, 4'hC, 32'h3333_4444);
      start = cyc;
      for (int i = 0; i < 4; i++) begin
         int g;
         g = first ^ (i % 2);
         if (g == 0)
            sb.push_back(mk_exp(0, 1'b0, 16'h0200, 4'h3, 32'h1111_2222, 0, 32'h0BAD_F00D, start + 3 * i));
         else
            sb.push_back(mk_exp(1, 1'b1, 16'h0300, 4'hC, 32'h3333_4444, 0, 32'h0BAD_F00D, start + 3 * i));
      end
      m0_req = 1'b1;
      m1_req = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(posedge clk); #1;
         if (m0_ack || m1_ack) n++;
      end
      check("contention_acks", n, 4);
      @(negedge clk);
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m1_req = 1'b0;
      set_master(0, 1'b0, 16'h0, 4'h0, 32'h0);
      set_master(1, 1'b0, 16'h0, 4'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_bus",
            {peripheralEnable, peripheralBus_we, peripheralBus_oe, peripheralBus_address,
             peripheralBus_byteSelect, peripheralBus_dataWrite}, 0);
      check("reset_resp", {m0_ack, m1_ack, m0_error, m1_error}, 0);
      check("reset_rdata", {m0_dataRead, m1_dataRead}, 0);
      @(negedge clk);
      rst = 1'b0;

      // single read, single write
      run_txn(0, 1'b0, 16'h0104, 4'hF, 32'h0, 0, 32'h0000_A5A5);
      run_txn(1, 1'b1, 16'h0101, 4'hF, 32'h1234_5678, 0, 32'h5555_5555);
      // pointer favours m0 after an m1 grant
      run_contention(0);
      // after an m0 grant the tie goes to m1
      run_txn(0, 1'b0, 16'h0010, 4'h1, 32'h0, 0, 32'h0000_0001);
      run_contention(1);
      // wait states and timeout boundary
      run_txn(0, 1'b0, 16'h0400, 4'hF, 32'h0, 3, 32'hCAFE_F00D);
      run_txn(1, 1'b1, 16'h0404, 4'h5, 32'hA0A0_B1B1, 2, 32'h7777_7777);
      run_txn(1, 1'b0, 16'h0408, 4'hF, 32'h0, 20, 32'h1234_4321);
      run_txn(0, 1'b0, 16'h040C, 4'hF, 32'h0, TB_TIMEOUT, 32'h0F0F_0F0F);
      run_txn(0, 1'b0, 16'h0410, 4'hF, 32'h0, TB_TIMEOUT - 1, 32'h6666_9999);

      // m0 grant leaves pointer favouring m1, then reset mid-ACTIVE must abort and favour m0
      run_txn(0, 1'b0, 16'h0500, 4'hF, 32'h0, 0, 32'h0000_0500);
      @(negedge clk);
      busy_len = 10;
      set_master(0, 1'b0, 16'h0600, 4'hF, 32'h0);
      sb.push_back(mk_exp(0, 1'b0, 16'h0600, 4'hF, 32'h0, 10, 32'h0, cyc));
      m0_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      m0_req = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      check("midrst_bus",
            {peripheralEnable, peripheralBus_we, peripheralBus_oe, peripheralBus_address,
             peripheralBus_byteSelect, peripheralBus_dataWrite}, 0);
      check("midrst_ack", {m0_ack, m1_ack, m0_error, m1_error}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      run_contention(0);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
